move_input_ctrl: RTL

MOVE_INPUT_CTRL -- requirements
Module: move_input_ctrl

---
 rtl/move_input_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/move_input_ctrl.sv
// move_input_ctrl: debounced move-commit button plus one-hot row/col capture, offered as a valid/ready move.
// Optional MOVE_INPUT_STICKY_ERR_EN: keep move_err high from a failed check until the next good move.
module move_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       Reset_n,
    input  logic       BtnU,
    input  logic [7:0] Row,
    input  logic [7:0] Col,
    input  logic       move_ready,
    output logic       move_valid,
    output logic [2:0] move_row,
    output logic [2:0] move_col,
    output logic       move_err,
    output logic       busy
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;

    typedef enum logic [2:0] {IDLE, DEB_PRESS, CHECK, REQ, WAIT_RELEASE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic [1:0]    btn_sync;
    logic [1:0]    vld;
    logic [7:0]    row_m, row_s, col_m, col_s;
    logic          btn, armed, row_ok, col_ok, deb_done, rel_done;

    function automatic logic [2:0] enc(input logic [7:0] v);
        enc = '0;
        for (int i = 0; i < 8; i++)
            if (v[i]) enc = 3'(i);
    endfunction

    always_ff @(posedge clk or negedge Reset_n)
        if (!Reset_n) begin
            btn_sync <= '0;
            row_m    <= '0;
            row_s    <= '0;
            col_m    <= '0;
            col_s    <= '0;
            vld      <= '0;
        end else begin
            btn_sync <= {btn_sync[0], BtnU};
            row_m    <= Row;
            row_s    <= row_m;
            col_m    <= Col;
            col_s    <= col_m;
            vld      <= {vld[0], 1'b1};
        end

    assign btn      = btn_sync[1];
    assign row_ok   = (row_s != '0) && ((row_s & (row_s - 8'd1)) == '0);
    assign col_ok   = (col_s != '0) && ((col_s & (col_s - 8'd1)) == '0);
    assign cnt_inc  = (&cnt) ? cnt : cnt + CW'(1);
    // The IDLE->DEB_PRESS edge already counts as the first stable cycle.
    assign deb_done = 32'(cnt) + 32'd2 >= 32'(DEBOUNCE_CYCLES);
    assign rel_done = 32'(cnt) + 32'd1 >= 32'(DEBOUNCE_CYCLES);

    // armed needs a genuine synchronised 0 after reset, so a button held through reset is not a press.
    always_ff @(posedge clk or negedge Reset_n)
        if (!Reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            armed      <= 1'b0;
            move_valid <= 1'b0;
            move_row   <= '0;
            move_col   <= '0;
            move_err   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            armed <= armed | (vld[1] & ~btn);
`ifndef MOVE_INPUT_STICKY_ERR_EN
            move_err <= 1'b0;
`endif
            case (state)
                IDLE:
                    if (armed && btn) begin
                        state <= DEB_PRESS;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                DEB_PRESS:
                    if (!btn) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (deb_done)
                        state <= CHECK;
                    else
                        cnt <= cnt_inc;
                CHECK: begin
                    cnt <= '0;
                    if (row_ok && col_ok) begin
                        move_row   <= enc(row_s);
                        move_col   <= enc(col_s);
                        move_err   <= 1'b0;
                        move_valid <= 1'b1;
                        state      <= REQ;
                    end else begin
                        move_err <= 1'b1;
                        state    <= WAIT_RELEASE;
                    end
                end
                REQ:
                    if (move_ready) begin
                        move_valid <= 1'b0;
                        state      <= WAIT_RELEASE;
                    end
                WAIT_RELEASE:
                    if (btn)
                        cnt <= '0;
                    else if (rel_done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else
                        cnt <= cnt_inc;
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
endmodule
